imu_spi_reader: RTL and testbench

IMU_SPI_READER -- requirements
Module: imu_spi_reader

---
 rtl/imu_spi_reader_pkg.sv | 22 ++
 rtl/imu_spi_reader_spi_word_shift.sv | 45 ++++
 rtl/imu_spi_reader.sv | 197 +++++++++++++++++++
 tb/tb_imu_spi_reader.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imu_spi_reader_pkg.sv
// Shared definitions for the IMU SPI burst reader: FSM states, SPI word width
// and the layout of the request word sent at the start of every burst.
package imu_spi_reader_pkg;

    localparam int SPI_WORD_W = 32;
    localparam int BIT_CNT_W  = $clog2(SPI_WORD_W);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        GAP,
        RSP,
        DONE
    } state_t;

    // Request word: command in the top byte, start register next, low half zero.
    function automatic logic [SPI_WORD_W-1:0] build_request(input logic [7:0] cmd,
                                                            input logic [7:0] reg_idx);
        return {cmd, reg_idx, 16'h0000};
    endfunction

endpackage

// File: rtl/imu_spi_reader_spi_word_shift.sv
// Single 32-bit shift register and bit counter shared by the request (transmit)
// and response (receive) frames; mosi is only updated on load or sck falling.
module spi_word_shift
    import imu_spi_reader_pkg::*;
(
    input  logic                  c,
    input  logic                  rst,
    input  logic                  load,
    input  logic [SPI_WORD_W-1:0] load_word,
    input  logic                  tx_en,
    input  logic                  fall,
    input  logic                  rise,
    input  logic                  miso,
    output logic                  mosi,
    output logic [SPI_WORD_W-1:0] word,
    output logic                  word_done
);

    logic [BIT_CNT_W-1:0] bit_cnt;

    // The outgoing MSB leaves on each rise while the incoming bit enters the LSB,
    // so after 32 rises the register holds exactly the received word.
    always_ff @(posedge c) begin
        if (rst) begin
            word      <= '0;
            bit_cnt   <= '0;
            mosi      <= 1'b0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (load) begin
                word    <= load_word;
                bit_cnt <= '0;
                mosi    <= tx_en & load_word[SPI_WORD_W-1];
            end else if (rise) begin
                word      <= {word[SPI_WORD_W-2:0], miso};
                bit_cnt   <= bit_cnt + 1'b1;
                word_done <= (bit_cnt == BIT_CNT_W'(SPI_WORD_W - 1));
            end else if (fall) begin
                mosi <= tx_en & word[SPI_WORD_W-1];
            end
        end
    end

endmodule

// File: rtl/imu_spi_reader.sv
// SPI mode-3 burst reader: on each synchronized sync rising edge it sends a
// request word, waits CS_GAP cycles, then reads NUM_WORDS+1 words (first dropped).
module imu_spi_reader
    import imu_spi_reader_pkg::*;
#(
    parameter int SCK_HALF  = 4,
    parameter int NUM_WORDS = 4,
    parameter int CS_GAP    = 8
)
(
    input  logic                  c,
    input  logic                  rst,
    input  logic                  sync,
    input  logic [7:0]            cmd,
    input  logic [7:0]            reg_idx,
    output logic                  cs,
    output logic                  sck,
    output logic                  mosi,
    input  logic                  miso,
    output logic [SPI_WORD_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rx_last,
    output logic                  busy,
    output logic [7:0]            missed
);

    state_t state;
    state_t next_state;

    logic sync_meta;
    logic sync_sync;
    logic sync_prev;
    logic trigger;

    logic [7:0] half_cnt;
    logic [7:0] gap_cnt;
    logic [4:0] word_cnt;

    logic in_frame;
    logic half_end;
    logic last_word;
    logic frame_end;
    logic gap_end;
    logic load;
    logic tx_en;
    logic rise;
    logic fall;

    logic [SPI_WORD_W-1:0] word;
    logic                  word_done;

    always_ff @(posedge c) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync_sync <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_meta <= sync;
            sync_sync <= sync_meta;
            sync_prev <= sync_sync;
        end
    end

    assign trigger = sync_sync & ~sync_prev;

    assign in_frame  = (state == REQ) || (state == RSP);
    assign half_end  = (half_cnt == 8'(SCK_HALF - 1));
    assign last_word = (state == REQ) ? (word_cnt == 5'd1)
                                      : (word_cnt == 5'(NUM_WORDS + 1));
    // A frame closes at the end of the final high phase; sck then simply stays high.
    assign frame_end = in_frame && half_end && sck && last_word;
    assign gap_end   = (gap_cnt == 8'(CS_GAP - 1));
    assign rise      = in_frame && half_end && !sck;
    assign fall      = in_frame && half_end && sck && !last_word;
    assign tx_en     = (state == IDLE) || (state == REQ);

    always_ff @(posedge c) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        unique case (state)
            IDLE: begin
                if (trigger) begin
                    next_state = REQ;
                    load       = 1'b1;
                end
            end
            REQ: begin
                if (frame_end) begin
                    next_state = GAP;
                end
            end
            GAP: begin
                if (gap_end) begin
                    next_state = RSP;
                    load       = 1'b1;
                end
            end
            RSP: begin
                if (frame_end) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Loading a frame pulls sck low together with cs, opening the first low phase.
    always_ff @(posedge c) begin
        if (rst) begin
            sck      <= 1'b1;
            half_cnt <= '0;
            word_cnt <= '0;
        end else if (load) begin
            sck      <= 1'b0;
            half_cnt <= '0;
            word_cnt <= '0;
        end else begin
            if (in_frame) begin
                if (half_end) begin
                    half_cnt <= '0;
                    if (!sck) begin
                        sck <= 1'b1;
                    end else if (!last_word) begin
                        sck <= 1'b0;
                    end
                end else begin
                    half_cnt <= half_cnt + 8'd1;
                end
            end
            if (word_done) begin
                word_cnt <= word_cnt + 5'd1;
            end
        end
    end

    always_ff @(posedge c) begin
        if (rst || state != GAP) begin
            gap_cnt <= '0;
        end else begin
            gap_cnt <= gap_cnt + 8'd1;
        end
    end

    // The request word is captured into the shifter at the trigger itself.
    spi_word_shift u_shift (
        .c         (c),
        .rst       (rst),
        .load      (load),
        .load_word (build_request(cmd, reg_idx)),
        .tx_en     (tx_en),
        .fall      (fall),
        .rise      (rise),
        .miso      (miso),
        .mosi      (mosi),
        .word      (word),
        .word_done (word_done)
    );

    // Response word 0 is the IMU's dummy reply to the request and is never presented.
    always_ff @(posedge c) begin
        if (rst) begin
            cs       <= 1'b1;
            busy     <= 1'b0;
            missed   <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_last  <= 1'b0;
        end else begin
            cs       <= !((next_state == REQ) || (next_state == RSP));
            busy     <= (next_state != IDLE);
            rx_valid <= 1'b0;
            rx_last  <= 1'b0;
            if (word_done && state == RSP && word_cnt != 5'd0) begin
                rx_data  <= word;
                rx_valid <= 1'b1;
                rx_last  <= (word_cnt == 5'(NUM_WORDS));
            end
            if (trigger && state != IDLE && missed != 8'hFF) begin
                missed <= missed + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_imu_spi_reader.sv
// Randomized self-checking bench: an SPI mode-3 IMU model returns incrementing
// register bytes; requests, received words, timing and drop counts are checked.
module tb_imu_spi_reader;

    localparam int SCK_HALF  = 2;
    localparam int NUM_WORDS = 4;
    localparam int CS_GAP    = 8;
    localparam logic [31:0] DUMMY_WORD = 32'hC3A5_5A3C;

    logic        c = 1'b0;
    logic        rst;
    logic        sync;
    logic [7:0]  cmd;
    logic [7:0]  reg_idx;
    logic        cs;
    logic        sck;
    logic        mosi;
    logic        miso = 1'b0;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_last;
    logic        busy;
    logic [7:0]  missed;

    int tests_run    = 0;
    int tests_failed = 0;

    imu_spi_reader #(
        .SCK_HALF  (SCK_HALF),
        .NUM_WORDS (NUM_WORDS),
        .CS_GAP    (CS_GAP)
    ) dut (
        .c        (c),
        .rst      (rst),
        .sync     (sync),
        .cmd      (cmd),
        .reg_idx  (reg_idx),
        .cs       (cs),
        .sck      (sck),
        .mosi     (mosi),
        .miso     (miso),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_last  (rx_last),
        .busy     (busy),
        .missed   (missed)
    );

    always #5 c = ~c;

    // Data word w of a burst starting at register base: four consecutive register bytes.
    function automatic logic [31:0] data_word(input logic [7:0] base, input int w);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            v[31-8*i -: 8] = base + 8'(4*w + i);
        end
        return v;
    endfunction

    function automatic logic rsp_bit(input logic [7:0] base, input int k);
        logic [31:0] w;
        w = (k / 32 == 0) ? DUMMY_WORD : data_word(base, k / 32 - 1);
        return w[31 - (k % 32)];
    endfunction

    // IMU model and monitors, evaluated on the falling edge of c.
    logic        cs_q = 1'b1;
    logic        sck_q = 1'b1;
    logic        mosi_q = 1'b0;
    logic        frame_is_rsp = 1'b0;
    logic        expect_rsp = 1'b0;
    logic        run_valid = 1'b0;
    int          fall_cnt = 0;
    int          sck_run = 0;
    int          cs_high_run = 0;
    int          phase_errs = 0;
    int          mosi_errs = 0;
    logic [31:0] req_shift = '0;
    logic [7:0]  cur_reg = '0;
    logic [31:0] req_log[$];
    int          gap_log[$];
    logic [32:0] rx_log[$];

    always @(negedge c) begin
        if (rx_valid) rx_log.push_back({rx_last, rx_data});
        if (rst) begin
            expect_rsp   = 1'b0;
            frame_is_rsp = 1'b0;
            run_valid    = 1'b0;
            cs_high_run  = 0;
            miso         = 1'b0;
        end else begin
            if (cs_q && !cs) begin
                frame_is_rsp = expect_rsp;
                fall_cnt     = 0;
                req_shift    = '0;
                if (expect_rsp) gap_log.push_back(cs_high_run);
                cs_high_run = 0;
            end
            if (sck != sck_q) begin
                if (run_valid && sck_run != SCK_HALF) phase_errs++;
                run_valid = !cs;
                sck_run   = 1;
                if (!cs && !sck) begin
                    miso = frame_is_rsp ? rsp_bit(cur_reg, fall_cnt) : 1'b0;
                    fall_cnt++;
                end
                if (!cs && sck) begin
                    if (frame_is_rsp) begin
                        if (mosi !== 1'b0) mosi_errs++;
                    end else begin
                        req_shift = {req_shift[30:0], mosi};
                    end
                end
            end else begin
                sck_run++;
            end
            if (mosi !== mosi_q && !(sck_q && !sck)) mosi_errs++;
            if (!cs_q && cs) begin
                run_valid = 1'b0;
                if (frame_is_rsp) begin
                    expect_rsp = 1'b0;
                end else begin
                    req_log.push_back(req_shift);
                    cur_reg    = req_shift[23:16];
                    expect_rsp = 1'b1;
                end
            end
            if (cs) cs_high_run++;
        end
        cs_q   = cs;
        sck_q  = sck;
        mosi_q = mosi;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic pulse_sync();
        @(negedge c);
        #1 sync = 1'b1;
        repeat (3) @(negedge c);
        #1 sync = 1'b0;
        repeat (2) @(negedge c);
    endtask

    task automatic applyStimulus(input logic [7:0] c8, input logic [7:0] r8);
        @(negedge c);
        #1;
        cmd     = c8;
        reg_idx = r8;
        pulse_sync();
    endtask

    task automatic wait_busy_rise();
        int n = 0;
        while (busy !== 1'b1 && n < 20) begin
            @(negedge c);
            n++;
        end
        checkOutput("busy_rise", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 4000) begin
            @(negedge c);
            n++;
        end
        checkOutput("busy_fall", {31'd0, busy}, 32'd0);
        repeat (5) @(negedge c);
    endtask

    task automatic check_burst(input logic [7:0] c8, input logic [7:0] r8,
                               input int req_base, input int gap_base, input int rx_base);
        checkOutput("req_count", 32'(req_log.size()), 32'(req_base + 1));
        if (req_log.size() > req_base)
            checkOutput("request", req_log[req_base], {c8, r8, 16'h0000});
        if (gap_log.size() > gap_base)
            checkOutput("cs_gap", 32'(gap_log[gap_base]), 32'(CS_GAP));
        else
            checkOutput("cs_gap_seen", 32'(gap_log.size()), 32'(gap_base + 1));
        checkOutput("rx_count", 32'(rx_log.size()), 32'(rx_base + NUM_WORDS));
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (rx_base + i < rx_log.size()) begin
                checkOutput("rx_data", rx_log[rx_base + i][31:0], data_word(r8, i));
                checkOutput("rx_last", {31'd0, rx_log[rx_base + i][32]},
                            {31'd0, (i == NUM_WORDS - 1)});
            end
        end
    endtask

    task automatic run_and_check(input logic [7:0] c8, input logic [7:0] r8);
        int req_base = req_log.size();
        int gap_base = gap_log.size();
        int rx_base  = rx_log.size();
        applyStimulus(c8, r8);
        wait_busy_rise();
        #1;
        cmd     = ~c8;
        reg_idx = r8 ^ 8'h5A;
        wait_idle();
        check_burst(c8, r8, req_base, gap_base, rx_base);
    endtask

    initial begin
        logic [7:0] bc;
        logic [7:0] br;
        int         req_base;
        int         gap_base;
        int         rx_base;
        int         rx_mark;
        int         n;

        rst     = 1'b1;
        sync    = 1'b0;
        cmd     = '0;
        reg_idx = '0;
        repeat (4) @(negedge c);
        checkOutput("reset_cs", {31'd0, cs}, 32'd1);
        checkOutput("reset_sck", {31'd0, sck}, 32'd1);
        checkOutput("reset_mosi", {31'd0, mosi}, 32'd0);
        checkOutput("reset_rx_data", rx_data, 32'd0);
        checkOutput("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("reset_rx_last", {31'd0, rx_last}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_missed", {24'd0, missed}, 32'd0);
        #1 rst = 1'b0;
        repeat (3) @(negedge c);

        for (int k = 0; k < 6; k++) begin
            bc = (k == 0) ? 8'h80 : 8'($urandom);
            br = (k == 0) ? 8'h10 : (k == 1) ? 8'h00 : 8'($urandom);
            run_and_check(bc, br);
        end
        checkOutput("no_missed_yet", {24'd0, missed}, 32'd0);

        // Second sync inside a burst is dropped and counted.
        bc = 8'($urandom);
        br = 8'($urandom);
        req_base = req_log.size();
        gap_base = gap_log.size();
        rx_base  = rx_log.size();
        applyStimulus(bc, br);
        wait_busy_rise();
        repeat (350) @(negedge c);
        checkOutput("still_busy", {31'd0, busy}, 32'd1);
        pulse_sync();
        wait_idle();
        checkOutput("missed_one", {24'd0, missed}, 32'd1);
        check_burst(bc, br, req_base, gap_base, rx_base);
        repeat (200) @(negedge c);
        checkOutput("single_burst", 32'(req_log.size()), 32'(req_base + 1));

        // Reset during the response frame aborts the burst.
        applyStimulus(8'($urandom), 8'($urandom));
        n = 0;
        while (!(frame_is_rsp && !cs) && n < 3000) begin
            @(negedge c);
            n++;
        end
        checkOutput("reach_rsp", {31'd0, frame_is_rsp && !cs}, 32'd1);
        repeat ($urandom_range(20, 400)) @(negedge c);
        @(negedge c);
        #1;
        rx_mark = rx_log.size();
        rst     = 1'b1;
        @(negedge c);
        checkOutput("abort_cs", {31'd0, cs}, 32'd1);
        checkOutput("abort_sck", {31'd0, sck}, 32'd1);
        checkOutput("abort_rx_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("abort_missed", {24'd0, missed}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        #1 rst = 1'b0;
        repeat (300) @(negedge c);
        checkOutput("abort_no_rx", 32'(rx_log.size()), 32'(rx_mark));
        run_and_check(8'($urandom), 8'($urandom));

        // Continuous triggers drive the drop counter into saturation.
        for (int k = 0; k < 350; k++) begin
            pulse_sync();
        end
        wait_idle();
        checkOutput("missed_saturated", {24'd0, missed}, 32'h0000_00FF);

        checkOutput("sck_phase_errors", 32'(phase_errs), 32'd0);
        checkOutput("mosi_errors", 32'(mosi_errs), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
